// File: rtl/gpc31_3_preimage_enum_pkg.sv
// Shared constants for the gpc31_3 preimage enumerator: code-space geometry
// for the default 1+3 column shape and the FSM state encodings.
package gpc_pkg;

  localparam int unsigned GPC_N0 = 1;
  localparam int unsigned GPC_N1 = 3;
  localparam int unsigned CODE_W = GPC_N0 + GPC_N1;
  localparam int unsigned CODES  = 2 ** CODE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gpc31_3_preimage_enum_weight_sum.sv
// Combinational weighted sum of a packed GPC code:
// each column-0 bit counts 1, each column-1 bit counts 2.
module gpc_weight_sum #(
  parameter int unsigned N0    = 1,
  parameter int unsigned N1    = 3,
  parameter int unsigned OUT_W = 3
) (
  input  logic [N0+N1-1:0] code_i,
  output logic [OUT_W:0]   sum_o
);

  // Accumulate at OUT_W+1 bits so the maximum sum never wraps.
  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < N0; i++) begin
      sum_o = sum_o + {{OUT_W{1'b0}}, code_i[i]};
    end
    for (int unsigned i = 0; i < N1; i++) begin
      sum_o = sum_o + {{(OUT_W-1){1'b0}}, code_i[N0+i], 1'b0};
    end
  end

endmodule

// File: rtl/gpc31_3_preimage_enum.sv
// Decoder-side enumerator for the gpc31_3 compressor: for a requested target
// value, scans every code {src1, src0} in ascending order and streams out the
// codes whose weighted sum equals the target, then pulses done with the count.
module gpc31_3_preimage_enum
  import gpc_pkg::*;
#(
  parameter int unsigned N0    = 1,
  parameter int unsigned N1    = 3,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N0-1:0]    out_src0,
  output logic [N1-1:0]    out_src1,
  output logic             done_valid,
  output logic [N0+N1:0]   done_count
);

  localparam int unsigned        CW     = N0 + N1;
  localparam logic [CW-1:0]      LAST_K = '1;
  localparam logic [CW:0]        ONE    = (CW+1)'(1);

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] target_q, target_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [N0-1:0]    src0_q, src0_d;
  logic [N1-1:0]    src1_q, src1_d;
  logic [CW:0]      done_count_q, done_count_d;

  logic [OUT_W:0]   k_sum;
  logic             examine;
  logic             match;

  gpc_weight_sum #(
    .N0    (N0),
    .N1    (N1),
    .OUT_W (OUT_W)
  ) u_weight_sum (
    .code_i (k_q),
    .sum_o  (k_sum)
  );

  // A code is examined only when the output register is free or being freed.
  assign examine = (state_q == ST_SCAN) && (!out_valid_q || out_ready);
  assign match   = (k_sum == {1'b0, target_q});

  // Next-state logic: request latch, code scan with beat back-pressure, done.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    k_d          = k_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q && !out_ready;
    src0_d       = src0_q;
    src1_d       = src1_q;
    done_count_d = done_count_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_SCAN;
          target_d = req_value;
          k_d      = '0;
          count_d  = '0;
        end
      end
      ST_SCAN: begin
        if (examine) begin
          if (match) begin
            out_valid_d = 1'b1;
            src0_d      = k_q[N0-1:0];
            src1_d      = k_q[CW-1:N0];
            count_d     = count_q + ONE;
          end
          // The final code's own match must be included in the reported count.
          if (k_q == LAST_K) begin
            state_d      = ST_DONE;
            done_count_d = match ? (count_q + ONE) : count_q;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset discarding any scan or pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      k_q          <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      src0_q       <= '0;
      src1_q       <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      k_q          <= k_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      done_count_q <= done_count_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_count = done_count_q;
  assign out_valid  = out_valid_q;
  assign out_src0   = src0_q;
  assign out_src1   = src1_q;

endmodule

// File: tb/tb_gpc31_3_preimage_enum.sv
// Scoreboard bench for gpc31_3_preimage_enum: directed requests push expected
// beats and done counts; a negedge monitor pops and compares.
module tb_gpc31_3_preimage_enum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_value = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [0:0] out_src0;
  logic [2:0] out_src1;
  logic       done_valid;
  logic [4:0] done_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned beats_seen = 0;

  logic [3:0] beat_q[$];
  logic [4:0] done_q[$];
  logic [2:0] cur_target = '0;
  logic [3:0] ws_sum;
  bit         stall_mode = 1'b0;
  bit         acc_seen = 1'b0;

  gpc31_3_preimage_enum #(
    .N0    (1),
    .N1    (3),
    .OUT_W (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_value  (req_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src0   (out_src0),
    .out_src1   (out_src1),
    .done_valid (done_valid),
    .done_count (done_count)
  );

  gpc_weight_sum #(
    .N0    (1),
    .N1    (3),
    .OUT_W (3)
  ) u_ws (
    .code_i ({out_src1, out_src0}),
    .sum_o  (ws_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compare accepted beats and done pulses against the queues.
  initial begin
    bit         prev_stall;
    logic [3:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_src1, out_src0}, prev_data);
      end
      if (out_valid && out_ready) begin
        acc_seen = 1'b1;
        beats_seen++;
        if (beat_q.size() == 0)
          check("unexpected_beat", beat_q.size(), 1);
        else begin
          check("beat_code", {out_src1, out_src0}, beat_q.pop_front());
          check("beat_sum", ws_sum, {1'b0, cur_target});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = {out_src1, out_src0};
      if (done_valid) begin
        if (done_q.size() == 0)
          check("unexpected_done", done_q.size(), 1);
        else
          check("done_count", done_count, done_q.pop_front());
      end
    end
  end

  // Downstream driver: always ready, or in stall mode holds each beat 4 cycles.
  initial begin
    int unsigned stall_cnt;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        out_ready = 1'b1;
        stall_cnt = 0;
        acc_seen  = 1'b0;
      end else begin
        if (acc_seen) begin
          stall_cnt = 0;
          acc_seen  = 1'b0;
        end
        if (out_valid && stall_cnt < 4) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns the handshake cycle T.
  task automatic request(input logic [2:0] v, output int unsigned t);
    int unsigned n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_value  = v;
    cur_target = v;
    t = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int unsigned dc);
    int unsigned n;
    n  = 0;
    dc = 0;
    forever begin
      @(negedge clk);
      if (done_valid) begin
        dc = cyc;
        break;
      end
      check("req_ready_busy", req_ready, 0);
      n++;
      if (n > 400) begin
        check("done_timeout", done_valid, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_codes [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h9,
                                   4'h6, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
  logic [4:0] sweep_cnt [8] = '{5'd1, 5'd1, 5'd3, 5'd3, 5'd3, 5'd3, 5'd1, 5'd1};

  initial begin
    int unsigned t, dc, idx, base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_src", {out_src1, out_src0}, 0);
    check("rst_done_count", done_count, 0);
    @(posedge clk);
    #1;

    // 1: target 0, done latency
    beat_q.push_back(4'h0);
    done_q.push_back(5'd1);
    request(3'd0, t);
    wait_done(dc);
    check("t1_done_latency", dc - t, 17);

    // 2: target 2
    beat_q.push_back(4'h2); beat_q.push_back(4'h4); beat_q.push_back(4'h8);
    done_q.push_back(5'd3);
    request(3'd2, t);
    wait_done(dc);
    check("t2_done_latency", dc - t, 17);

    // 3: target 7, match on the last code
    beat_q.push_back(4'hF);
    done_q.push_back(5'd1);
    request(3'd7, t);
    wait_done(dc);

    // 4: target 5 under back-pressure
    stall_mode = 1'b1;
    beat_q.push_back(4'h7); beat_q.push_back(4'hB); beat_q.push_back(4'hD);
    done_q.push_back(5'd3);
    request(3'd5, t);
    wait_done(dc);
    check("t4_stall_extends", (dc - t) > 17, 1);
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5: sweep all targets back-to-back
    base = beats_seen;
    idx  = 0;
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < int'(sweep_cnt[v]); j++) begin
        beat_q.push_back(sweep_codes[idx]);
        idx++;
      end
      done_q.push_back(sweep_cnt[v]);
      request(3'(v), t);
      wait_done(dc);
    end
    repeat (2) @(posedge clk);
    #1;
    check("t5_total_beats", beats_seen - base, 16);

    // 6: reset mid-scan, then rerun target 3
    beat_q.push_back(4'h3); beat_q.push_back(4'h5); beat_q.push_back(4'h9);
    done_q.push_back(5'd3);
    request(3'd3, t);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    beat_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_req_ready", req_ready, 1);
    check("t6_out_valid", out_valid, 0);
    check("t6_done_valid", done_valid, 0);
    check("t6_src", {out_src1, out_src0}, 0);
    check("t6_done_count", done_count, 0);
    repeat (20) @(posedge clk);
    #1;
    beat_q.push_back(4'h3); beat_q.push_back(4'h5); beat_q.push_back(4'h9);
    done_q.push_back(5'd3);
    request(3'd3, t);
    wait_done(dc);
    check("t6_done_latency", dc - t, 17);

    repeat (4) @(posedge clk);
    #1;
    check("beats_drained", beat_q.size(), 0);
    check("dones_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
